// File: rtl/pulse_pkg.sv
// Shared types and width helpers for the pulse stretcher.
// The width helpers keep the counter and queue exactly as wide as their largest value.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_e;

    function automatic int cnt_width(input int high_cycles, input int gap_cycles);
        int m;
        m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

    function automatic int pend_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_ev.sv
// Event qualifier: passes `in` through as a level event, or turns it into a
// single-cycle rising-edge event when EDGE_IN is set.
module pulse_stretcher_ev #(
    parameter int EDGE_IN = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic ev
);

    logic in_q;

    // Cleared to 0 so that `in` already high at reset release still counts as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign ev = (EDGE_IN != 0) ? (in & ~in_q) : in;

endmodule

// File: rtl/pulse_stretcher.sv
// Converts one-cycle event strobes into fixed-width high windows with a minimum
// low gap between windows, queueing events that arrive while a window is active.
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_DEPTH  = 3,
    parameter int RETRIGGER   = 0,
    parameter int EDGE_IN     = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in,
    output logic                              out,
    output logic                              busy,
    output logic [pend_width(PEND_DEPTH)-1:0] pending,
    output logic                              drop
);

    localparam int CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);
    localparam int PW = pend_width(PEND_DEPTH);

    localparam logic [CW-1:0] H_LOAD   = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] G_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [PW-1:0] PEND_MAX = PW'(PEND_DEPTH);

    if (HIGH_CYCLES < 1 || PEND_DEPTH < 1) begin : g_param_check
        $error("pulse_stretcher: HIGH_CYCLES and PEND_DEPTH must both be >= 1");
    end

    logic          ev;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          out_q, out_d;
    logic          drop_q, drop_d;
    logic          win_end, queue_ev, consume;

    pulse_stretcher_ev #(
        .EDGE_IN(EDGE_IN)
    ) u_ev (
        .clk(clk),
        .rst(rst),
        .in (in),
        .ev (ev)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        drop_d   = 1'b0;
        win_end  = 1'b0;
        queue_ev = 1'b0;
        consume  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ev) begin
                    state_d = HIGH;
                    cnt_d   = H_LOAD;
                end
            end
            HIGH: begin
                if (ev && RETRIGGER != 0) begin
                    cnt_d = H_LOAD;
                end else begin
                    queue_ev = ev;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = G_LOAD;
                    end else begin
                        win_end = 1'b1;
                    end
                end
            end
            GAP: begin
                queue_ev = ev;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    win_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An event arriving exactly at window end is queued and consumed in the same cycle.
        if (win_end) begin
            if (pend_q != '0 || ev) begin
                state_d = HIGH;
                cnt_d   = H_LOAD;
                consume = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        if (queue_ev && !consume && pend_q == PEND_MAX) begin
            drop_d = 1'b1;
        end else begin
            pend_d = pend_q + PW'(queue_ev) - PW'(consume);
        end

        out_d = (state_d == HIGH);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    assign out     = out_q;
    assign busy    = (state_q != IDLE);
    assign pending = pend_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench: four stretcher configurations driven by one input stream,
// each compared every cycle against a window-timeline reference model.
module tb_pulse_stretcher;

    localparam int NCFG = 4;
    // cfg0 default, cfg1 retrigger, cfg2 edge input, cfg3 no gap / shallow queue
    localparam int CFG_H [NCFG] = '{4, 4, 4, 2};
    localparam int CFG_G [NCFG] = '{2, 2, 2, 0};
    localparam int CFG_D [NCFG] = '{3, 3, 3, 2};
    localparam int CFG_R [NCFG] = '{0, 1, 0, 0};
    localparam int CFG_E [NCFG] = '{0, 0, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_r = 1'b0;
    logic       out_w  [NCFG];
    logic       busy_w [NCFG];
    logic       drop_w [NCFG];
    logic [1:0] pend_w [NCFG];

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;

    // Reference model: a window starts at cycle m_s and ends at m_s + H + G.
    int m_s    [NCFG];
    int m_pend [NCFG];
    bit m_busy [NCFG];
    bit m_drop [NCFG];
    bit m_prev [NCFG];

    always #5 clk = ~clk;

    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_DEPTH(3), .RETRIGGER(0), .EDGE_IN(0)) u_dut (
        .clk(clk), .rst(rst), .in(in_r), .out(out_w[0]), .busy(busy_w[0]), .pending(pend_w[0]), .drop(drop_w[0]));
    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_DEPTH(3), .RETRIGGER(1), .EDGE_IN(0)) u_rt (
        .clk(clk), .rst(rst), .in(in_r), .out(out_w[1]), .busy(busy_w[1]), .pending(pend_w[1]), .drop(drop_w[1]));
    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_DEPTH(3), .RETRIGGER(0), .EDGE_IN(1)) u_ed (
        .clk(clk), .rst(rst), .in(in_r), .out(out_w[2]), .busy(busy_w[2]), .pending(pend_w[2]), .drop(drop_w[2]));
    pulse_stretcher #(.HIGH_CYCLES(2), .GAP_CYCLES(0), .PEND_DEPTH(2), .RETRIGGER(0), .EDGE_IN(0)) u_g0 (
        .clk(clk), .rst(rst), .in(in_r), .out(out_w[3]), .busy(busy_w[3]), .pending(pend_w[3]), .drop(drop_w[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCFG; k++) begin
            m_s[k] = 0; m_pend[k] = 0; m_busy[k] = 1'b0; m_drop[k] = 1'b0; m_prev[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input int t, input bit v);
        bit ev;
        ev = (CFG_E[k] != 0) ? (v & ~m_prev[k]) : v;
        m_prev[k] = v;
        m_drop[k] = 1'b0;
        if (!m_busy[k]) begin
            if (ev) begin
                m_busy[k] = 1'b1;
                m_s[k] = t;
            end
        end else if (CFG_R[k] != 0 && ev && t <= m_s[k] + CFG_H[k]) begin
            m_s[k] = t;
        end else if (t == m_s[k] + CFG_H[k] + CFG_G[k]) begin
            if (m_pend[k] > 0 || ev) begin
                m_s[k] = t;
                if (!ev) m_pend[k]--;
            end else begin
                m_busy[k] = 1'b0;
            end
        end else if (ev) begin
            if (m_pend[k] == CFG_D[k]) m_drop[k] = 1'b1;
            else m_pend[k]++;
        end
    endtask

    task automatic step(input logic v);
        in_r = v;
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NCFG; k++) model_step(k, cyc, v);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("cfg%0d out t=%0d", k, cyc), 32'(out_w[k]),
                  32'(m_busy[k] && cyc < m_s[k] + CFG_H[k]));
            check($sformatf("cfg%0d busy t=%0d", k, cyc), 32'(busy_w[k]), 32'(m_busy[k]));
            check($sformatf("cfg%0d pending t=%0d", k, cyc), 32'(pend_w[k]), 32'(m_pend[k]));
            check($sformatf("cfg%0d drop t=%0d", k, cyc), 32'(drop_w[k]), 32'(m_drop[k]));
        end
    endtask

    // Directed sequence with hand-written expected bit masks (bit i = after posedge p<i>).
    task automatic run_dir(input string name, input int idx, input int n, input logic [31:0] ins,
                           input logic [31:0] eout, input logic [31:0] ebusy, input logic [31:0] edrop);
        for (int i = 0; i < n; i++) begin
            step(ins[i]);
            check($sformatf("%s out p%0d", name, i), 32'(out_w[idx]), 32'(eout[i]));
            check($sformatf("%s busy p%0d", name, i), 32'(busy_w[idx]), 32'(ebusy[i]));
            check($sformatf("%s drop p%0d", name, i), 32'(drop_w[idx]), 32'(edrop[i]));
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("reset cfg%0d out", k), 32'(out_w[k]), 32'd0);
            check($sformatf("reset cfg%0d busy", k), 32'(busy_w[k]), 32'd0);
            check($sformatf("reset cfg%0d pending", k), 32'(pend_w[k]), 32'd0);
            check($sformatf("reset cfg%0d drop", k), 32'(drop_w[k]), 32'd0);
        end
        rst = 1'b0;

        run_dir("single", 0, 9, 32'h1, 32'hF, 32'h3F, 32'h0);
        run_dir("b2b", 0, 14, 32'h3, 32'h3CF, 32'hFFF, 32'h0);
        run_dir("overflow", 0, 26, 32'h1F, 32'h3CF3CF, 32'hFFFFFF, 32'h10);
        run_dir("retrig", 1, 10, 32'h5, 32'h3F, 32'hFF, 32'h0);
        repeat (12) step(1'b0);
        run_dir("edge", 2, 12, 32'h3FF, 32'hF, 32'h3F, 32'h0);

        for (int b = 0; b < 40; b++) begin
            int dens;
            int len;
            dens = int'($urandom_range(0, 100));
            len  = int'($urandom_range(5, 20));
            for (int j = 0; j < len; j++) step($urandom_range(0, 99) < dens);
        end

        // Asynchronous reset in the middle of a window with two events queued.
        repeat (30) step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("pre-reset pending", 32'(pend_w[0]), 32'd2);
        check("pre-reset out", 32'(out_w[0]), 32'd1);
        #1;
        rst = 1'b1;
        in_r = 1'b0;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("async rst cfg%0d out", k), 32'(out_w[k]), 32'd0);
            check($sformatf("async rst cfg%0d busy", k), 32'(busy_w[k]), 32'd0);
            check($sformatf("async rst cfg%0d pending", k), 32'(pend_w[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check($sformatf("post-reset out c%0d", i), 32'(out_w[0]), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
